// File: rtl/ram256.sv
// ram256: 256-byte big-endian data memory with a single synchronous port.
// Byte, halfword and word accesses; registered read data and MFC flag.
module ram256 (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] DataOut,
  output logic        MFC,
  input  logic        Enable,
  input  logic        RW,
  input  logic [7:0]  Address,
  input  logic [31:0] DataIn,
  input  logic [1:0]  DataSize
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Contents start at zero for simulation; reset never touches them.
  logic [7:0]  mem_q [256] = '{default: '0};
  logic [31:0] dout_q, dout_d;
  logic        mfc_q, mfc_d;
  logic [31:0] rdata;
  logic [7:0]  addr_h, addr_w;
  logic        wr_en;

  // Aligned base addresses: halfword drops bit 0, word drops bits 1:0.
  // Offsets are OR'ed in so an access never carries past 0xFF.
  assign addr_h = {Address[7:1], 1'b0};
  assign addr_w = {Address[7:2], 2'b00};
  assign wr_en  = Enable && !RW && !reset;

  // Read mux: zero-extended, big-endian assembly of the addressed bytes.
  always_comb begin
    rdata = '0;
    if (Enable && RW) begin
      case (DataSize)
        SZ_BYTE: rdata = {24'h0, mem_q[Address]};
        SZ_HALF: rdata = {16'h0, mem_q[addr_h], mem_q[addr_h | 8'd1]};
        SZ_WORD: rdata = {mem_q[addr_w], mem_q[addr_w | 8'd1],
                          mem_q[addr_w | 8'd2], mem_q[addr_w | 8'd3]};
        default: rdata = '0;
      endcase
    end
  end

  // Next-state for the output registers; reset discards the access.
  always_comb begin
    dout_d = reset ? '0 : rdata;
    mfc_d  = !reset && Enable;
  end

  // Memory array update; writes are suppressed while reset is high.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (DataSize)
        SZ_BYTE: mem_q[Address] <= DataIn[7:0];
        SZ_HALF: begin
          mem_q[addr_h]         <= DataIn[15:8];
          mem_q[addr_h | 8'd1]  <= DataIn[7:0];
        end
        SZ_WORD: begin
          mem_q[addr_w]         <= DataIn[31:24];
          mem_q[addr_w | 8'd1]  <= DataIn[23:16];
          mem_q[addr_w | 8'd2]  <= DataIn[15:8];
          mem_q[addr_w | 8'd3]  <= DataIn[7:0];
        end
        default: ;
      endcase
    end
  end

  // Output registers: read data and memory-function-complete flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
      mfc_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      mfc_q  <= mfc_d;
    end
  end

  assign DataOut = dout_q;
  assign MFC     = mfc_q;

endmodule

// File: tb/tb_ram256.sv
// tb_ram256: directed stimulus against a byte-array reference model,
// checked every cycle, plus literal expectations from the test plan.
module tb_ram256;

  logic        clk;
  logic        reset;
  logic [31:0] DataOut;
  logic        MFC;
  logic        Enable;
  logic        RW;
  logic [7:0]  Address;
  logic [31:0] DataIn;
  logic [1:0]  DataSize;

  int unsigned pass_cnt = 0;
  int unsigned tot_cnt  = 0;

  logic [7:0]  mdl [256];
  logic [31:0] exp_dout = '0;
  logic        exp_mfc  = 1'b0;

  ram256 dut (
    .clk      (clk),
    .reset    (reset),
    .DataOut  (DataOut),
    .MFC      (MFC),
    .Enable   (Enable),
    .RW       (RW),
    .Address  (Address),
    .DataIn   (DataIn),
    .DataSize (DataSize)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference model: an access touches n = 1,2,4 bytes at the n-aligned base,
  // most significant byte at the lowest address.
  always @(posedge clk) begin
    int n;
    int base;
    logic [31:0] v;
    v = '0;
    if (reset || !Enable) begin
      exp_dout = '0;
      exp_mfc  = 1'b0;
    end else begin
      exp_mfc = 1'b1;
      if (DataSize == 2'b11) begin
        exp_dout = '0;
      end else begin
        n    = 1 << DataSize;
        base = int'(Address) - (int'(Address) % n);
        if (RW) begin
          for (int i = 0; i < n; i++) v = (v << 8) | 32'(mdl[base + i]);
          exp_dout = v;
        end else begin
          for (int i = 0; i < n; i++) mdl[base + i] = 8'(DataIn >> (8 * (n - 1 - i)));
          exp_dout = '0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled after the edge settles.
  always @(posedge clk) begin
    #1;
    chk("cyc_dout", DataOut, exp_dout);
    chk("cyc_mfc", {31'h0, MFC}, {31'h0, exp_mfc});
  end

  task automatic acc(input logic rst, input logic en, input logic rw, input logic [7:0] a,
                     input logic [31:0] d, input logic [1:0] s);
    @(negedge clk);
    reset = rst; Enable = en; RW = rw; Address = a; DataIn = d; DataSize = s;
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    reset = 1'b1; Enable = 1'b0; RW = 1'b0; Address = '0; DataIn = '0; DataSize = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_dout", DataOut, 32'h0);
    chk("rst_mfc", {31'h0, MFC}, 32'h0);

    // Disabled access, then byte read of untouched memory
    acc(0, 0, 0, 8'h00, 32'hFFFFFFFF, 2'b00);
    chk("idle_mfc", {31'h0, MFC}, 32'h0);
    chk("idle_dout", DataOut, 32'h0);
    acc(0, 1, 1, 8'h00, 32'h0, 2'b00);
    chk("rd0_init", DataOut, 32'h00000000);
    chk("rd0_mfc", {31'h0, MFC}, 32'h1);

    // Byte write / read
    acc(0, 1, 0, 8'h00, 32'hFFFFFF0B, 2'b00);
    chk("wb_mfc", {31'h0, MFC}, 32'h1);
    chk("wb_dout", DataOut, 32'h0);
    acc(0, 1, 1, 8'h00, 32'h0, 2'b00);
    chk("rb_00", DataOut, 32'h0000000B);

    // Halfword write / read, misaligned read, per-byte readback
    acc(0, 1, 0, 8'hF0, 32'hABCDEF1A, 2'b01);
    acc(0, 1, 1, 8'hF0, 32'h0, 2'b01);
    chk("rh_F0", DataOut, 32'h0000EF1A);
    acc(0, 1, 1, 8'hF1, 32'h0, 2'b01);
    chk("rh_F1", DataOut, 32'h0000EF1A);
    acc(0, 1, 1, 8'hF0, 32'h0, 2'b00);
    chk("rb_F0", DataOut, 32'h000000EF);
    acc(0, 1, 1, 8'hF1, 32'h0, 2'b00);
    chk("rb_F1", DataOut, 32'h0000001A);

    // Word write at top of memory, no wrap
    acc(0, 1, 0, 8'hFC, 32'hABCDEF1C, 2'b10);
    acc(0, 1, 1, 8'hFC, 32'h0, 2'b10);
    chk("rw_FC", DataOut, 32'hABCDEF1C);
    acc(0, 1, 1, 8'hFC, 32'h0, 2'b00);
    chk("rb_FC", DataOut, 32'h000000AB);
    acc(0, 1, 1, 8'hFF, 32'h0, 2'b00);
    chk("rb_FF", DataOut, 32'h0000001C);
    acc(0, 1, 1, 8'hFE, 32'h0, 2'b10);
    chk("rw_FE", DataOut, 32'hABCDEF1C);
    acc(0, 1, 1, 8'h00, 32'h0, 2'b10);
    chk("rw_00", DataOut, 32'h0B000000);

    // Misaligned halfword write lands on the aligned pair
    acc(0, 1, 0, 8'h21, 32'h00005A6B, 2'b01);
    acc(0, 1, 1, 8'h20, 32'h0, 2'b10);
    chk("rw_20", DataOut, 32'h5A6B0000);

    // Reserved size: no write, read gives 0 with MFC
    acc(0, 1, 0, 8'h00, 32'hFFFFFFFF, 2'b11);
    acc(0, 1, 1, 8'h00, 32'h0, 2'b00);
    chk("rsv_keep", DataOut, 32'h0000000B);
    acc(0, 1, 1, 8'h00, 32'h0, 2'b11);
    chk("rsv_rd", DataOut, 32'h0);
    chk("rsv_mfc", {31'h0, MFC}, 32'h1);

    // Reset discards a concurrent write; memory survives
    acc(0, 1, 0, 8'h10, 32'h11223344, 2'b10);
    acc(1, 1, 0, 8'h10, 32'h12345678, 2'b10);
    chk("rstw_mfc", {31'h0, MFC}, 32'h0);
    chk("rstw_dout", DataOut, 32'h0);
    acc(0, 1, 1, 8'h10, 32'h0, 2'b10);
    chk("rstw_old", DataOut, 32'h11223344);
    acc(0, 1, 1, 8'hF0, 32'h0, 2'b01);
    chk("rstw_keep", DataOut, 32'h0000EF1A);

    // Reset during a read also clears outputs
    acc(1, 1, 1, 8'h10, 32'h0, 2'b10);
    chk("rstr_dout", DataOut, 32'h0);

    // Back-to-back random traffic, model checks each cycle
    for (int k = 0; k < 200; k++)
      acc(0, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
          8'($urandom_range(0, 255)), $urandom, 2'($urandom_range(0, 3)));

    acc(0, 0, 1, 8'h00, 32'h0, 2'b00);
    chk("end_mfc", {31'h0, MFC}, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
